turbo_iter_sched: RTL and testbench

- Half-iteration scheduler for the turbo decoder. It sequences one shared max-product BCJR SISO between constituent decoder 1 (natural order) and decoder 2 (interleaved order).
- Counts half-iterations, supports optional early termination, and triggers the final deinterleave when the last pass ends in the interleaved domain.
- Issues the frame-level out_valid.
- Sits between the frame input handshake and the SISO, interleaver and extrinsic-memory datapath.

---
 rtl/turbo_iter_sched.sv | 161 ++++++++++++++++
 tb/tb_turbo_iter_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_iter_sched.sv
// Half-iteration scheduler for the turbo decoder.
// One shared SISO alternates between decoder 1 (natural order) and decoder 2
// (interleaved order). The block counts half-iterations, honours early
// termination, runs the final deinterleave when the last pass ends in the
// interleaved domain, and guards every SISO/deinterleave wait with a watchdog.
// Every output is registered, and each pulse lasts exactly one cycle.
module turbo_iter_sched #(
   parameter int HALF_ITER     = 2,    // maximum half-iterations per frame
   parameter int MIN_HALF_ITER = 2,    // minimum before early stop is honoured
   parameter int TIMEOUT       = 1024, // watchdog cycles per wait, 0 = off
   parameter int CNT_W         = 8,
   parameter int TMR_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             ready,
   output logic             overrun,
   output logic             load_en,
   output logic             siso_start,
   input  logic             siso_done,
   output logic             siso_sel,
   output logic             apriori_zero,
   input  logic             early_stop_en,
   input  logic             converged,
   output logic             deint_start,
   input  logic             deint_done,
   output logic [CNT_W-1:0] half_iter_cnt,
   output logic             out_valid,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DEINT, S_DWAIT, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_ITER);
   localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_HALF_ITER);
   // When TIMEOUT is 0 this wraps to all ones, but WDOG_EN masks it.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic             WDOG_EN  = (TIMEOUT != 0);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] wdog_q, wdog_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             sel_q, sel_d;
   logic             apz_q, apz_d;
   logic             tmo_d, finish, expired;
   logic             ready_q, overrun_q, load_en_q, siso_start_q;
   logic             deint_start_q, out_valid_q, timeout_err_q;

   // Next-state, counter and watchdog logic.
   // NOTE: every signal gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      apz_d   = apz_q;
      tmo_d   = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      finish  = (cnt_inc == CNT_MAX) ||
                (early_stop_en && converged && (cnt_inc >= CNT_MIN));
      expired = WDOG_EN && (wdog_q == TMR_LAST);

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               sel_d   = 1'b0;
               apz_d   = 1'b1;
            end
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + TMR_W'(1);
            // A done that lands on the expiry cycle still counts.
            if (siso_done) begin
               cnt_d = cnt_inc;
               if (!finish) begin
                  sel_d   = ~sel_q;
                  apz_d   = 1'b0;
                  state_d = S_RUN;
               end else if (sel_q) begin
                  state_d = S_DEINT;
               end else begin
                  state_d = S_DONE;
               end
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DEINT: begin
            wdog_d  = '0;
            state_d = S_DWAIT;
         end
         S_DWAIT: begin
            wdog_d = wdog_q + TMR_W'(1);
            if (deint_done) begin
               state_d = S_DONE;
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and registered Moore outputs.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wdog_q        <= '0;
         cnt_q         <= '0;
         sel_q         <= 1'b0;
         apz_q         <= 1'b1;
         ready_q       <= 1'b1;
         overrun_q     <= 1'b0;
         load_en_q     <= 1'b0;
         siso_start_q  <= 1'b0;
         deint_start_q <= 1'b0;
         out_valid_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         apz_q         <= apz_d;
         ready_q       <= (state_d == S_IDLE);
         // A frame offered while busy is dropped and flagged.
         overrun_q     <= in_valid && !ready_q;
         load_en_q     <= (state_d == S_LOAD);
         siso_start_q  <= (state_d == S_RUN);
         deint_start_q <= (state_d == S_DEINT);
         out_valid_q   <= (state_d == S_DONE);
         timeout_err_q <= tmo_d;
      end
   end

   assign ready         = ready_q;
   assign overrun       = overrun_q;
   assign load_en       = load_en_q;
   assign siso_start    = siso_start_q;
   assign siso_sel      = sel_q;
   assign apriori_zero  = apz_q;
   assign deint_start   = deint_start_q;
   assign half_iter_cnt = cnt_q;
   assign out_valid     = out_valid_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_turbo_iter_sched.sv
// Bench for turbo_iter_sched: three configurations (2/3/8 half-iterations)
// driven by a reactive SISO/deinterleave responder. Expected event times are
// computed arithmetically from the pass delays before each frame starts.
module tb_turbo_iter_sched;

   localparam int N    = 3;
   localparam int HI0  = 2, MHI0 = 2, TMO0 = 16;
   localparam int HI1  = 3, MHI1 = 1, TMO1 = 1024;
   localparam int HI2  = 8, MHI2 = 2, TMO2 = 0;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid [N], siso_done [N], early [N], conv [N], deint_done [N];
   logic       ready [N], overrun [N], load_en [N], siso_start [N];
   logic       siso_sel [N], apriori_zero [N], deint_start [N];
   logic       out_valid [N], timeout_err [N];
   logic [7:0] hic [N];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Frame stimulus: per-pass SISO delay (-1 = never), converged flag, deint delay.
   int d_q [16];
   bit c_q [16];
   int e_dly;
   bit early_en;

   // Reference expectations for the current frame.
   int x_np, x_deint, x_outv, x_tmo, x_cnt;
   int x_start [16];
   bit x_sel [16], x_apz [16];

   always #5 clk = ~clk;

   turbo_iter_sched #(.HALF_ITER(HI0), .MIN_HALF_ITER(MHI0), .TIMEOUT(TMO0)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .ready(ready[0]),
      .overrun(overrun[0]), .load_en(load_en[0]), .siso_start(siso_start[0]),
      .siso_done(siso_done[0]), .siso_sel(siso_sel[0]), .apriori_zero(apriori_zero[0]),
      .early_stop_en(early[0]), .converged(conv[0]), .deint_start(deint_start[0]),
      .deint_done(deint_done[0]), .half_iter_cnt(hic[0]), .out_valid(out_valid[0]),
      .timeout_err(timeout_err[0]));

   turbo_iter_sched #(.HALF_ITER(HI1), .MIN_HALF_ITER(MHI1), .TIMEOUT(TMO1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .ready(ready[1]),
      .overrun(overrun[1]), .load_en(load_en[1]), .siso_start(siso_start[1]),
      .siso_done(siso_done[1]), .siso_sel(siso_sel[1]), .apriori_zero(apriori_zero[1]),
      .early_stop_en(early[1]), .converged(conv[1]), .deint_start(deint_start[1]),
      .deint_done(deint_done[1]), .half_iter_cnt(hic[1]), .out_valid(out_valid[1]),
      .timeout_err(timeout_err[1]));

   turbo_iter_sched #(.HALF_ITER(HI2), .MIN_HALF_ITER(MHI2), .TIMEOUT(TMO2)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .ready(ready[2]),
      .overrun(overrun[2]), .load_en(load_en[2]), .siso_start(siso_start[2]),
      .siso_done(siso_done[2]), .siso_sel(siso_sel[2]), .apriori_zero(apriori_zero[2]),
      .early_stop_en(early[2]), .converged(conv[2]), .deint_start(deint_start[2]),
      .deint_done(deint_done[2]), .half_iter_cnt(hic[2]), .out_valid(out_valid[2]),
      .timeout_err(timeout_err[2]));

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then stable for the new cycle.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int hi_of(input int d);
      return (d == 0) ? HI0 : (d == 1) ? HI1 : HI2;
   endfunction
   function automatic int mhi_of(input int d);
      return (d == 0) ? MHI0 : (d == 1) ? MHI1 : MHI2;
   endfunction
   function automatic int tmo_of(input int d);
      return (d == 0) ? TMO0 : (d == 1) ? TMO1 : TMO2;
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         in_valid[i]   = 1'b0;
         siso_done[i]  = 1'b0;
         deint_done[i] = 1'b0;
         early[i]      = 1'b0;
         conv[i]       = 1'b0;
      end
   endtask

   // Event schedule relative to the in_valid cycle (cycle 0): passes start
   // at 2 and each takes D+1 cycles; a pass whose done comes later than
   // TIMEOUT cycles after its start is aborted at start+TIMEOUT+1.
   function automatic void model(input int hi, input int mhi, input int tmo);
      int t;
      int k;
      t = 2;
      x_np = 0; x_deint = -1; x_outv = -1; x_tmo = -1; x_cnt = 0;
      for (int p = 0; p < hi; p++) begin
         x_start[p] = t;
         x_sel[p]   = (p % 2 == 1);
         x_apz[p]   = (p == 0);
         x_np++;
         if (d_q[p] < 0 || (tmo != 0 && d_q[p] > tmo)) begin
            x_tmo = t + tmo + 1;
            x_cnt = p;
            return;
         end
         k = p + 1;
         if (k == hi || (early_en && c_q[p] && k >= mhi)) begin
            x_cnt = k;
            if (p % 2 == 1) begin
               x_deint = t + d_q[p] + 1;
               if (e_dly < 0 || (tmo != 0 && e_dly > tmo)) x_tmo = x_deint + tmo + 1;
               else x_outv = x_deint + e_dly + 1;
            end else begin
               x_outv = t + d_q[p] + 1;
            end
            return;
         end
         t = t + d_q[p] + 1;
      end
   endfunction

   // Run one frame on DUT d. ov_in_arg: cycle to offer an extra frame
   // (-1 none, -2 the expected out_valid cycle). stray adds ignored dones.
   task automatic run_frame(input int d, input int ov_in_arg, input bit stray, input string nm);
      int hi, mhi, tmo, ov_in, t0, r, np, end_at, last_start, dstart, cnt_hold;
      int n_load, a_load, n_deint, a_deint, n_outv, a_outv, n_tmo, a_tmo, n_ovr, a_ovr;
      int a_start [16], a_cnt [16];
      bit a_sel [16], a_apz [16];
      logic rdy_end, rdy_after;
      hi = hi_of(d); mhi = mhi_of(d); tmo = tmo_of(d);
      model(hi, mhi, tmo);
      ov_in = (ov_in_arg == -2) ? x_outv : ov_in_arg;
      np = 0; end_at = -1; last_start = -1; dstart = -1; cnt_hold = -1;
      n_load = 0; a_load = -1; n_deint = 0; a_deint = -1; n_outv = 0; a_outv = -1;
      n_tmo = 0; a_tmo = -1; n_ovr = 0; a_ovr = -1; rdy_end = 1'bx; rdy_after = 1'bx;
      for (int i = 0; i < 16; i++) begin
         a_start[i] = -1; a_cnt[i] = -1; a_sel[i] = 1'b0; a_apz[i] = 1'b0;
      end
      early[d]    = early_en;
      in_valid[d] = 1'b1;
      t0 = cyc;
      for (int n = 0; n < 4000; n++) begin
         step();
         r = cyc - t0;
         if (load_en[d]) begin n_load++; a_load = r; end
         if (siso_start[d]) begin
            if (np < 16) begin
               a_start[np] = r; a_sel[np] = siso_sel[d];
               a_apz[np] = apriori_zero[d]; a_cnt[np] = int'(hic[d]);
            end
            np++;
            last_start = r;
         end
         if (deint_start[d]) begin n_deint++; a_deint = r; dstart = r; end
         if (out_valid[d]) begin
            n_outv++; a_outv = r;
            if (end_at < 0) begin end_at = r; rdy_end = ready[d]; end
         end
         if (timeout_err[d]) begin
            n_tmo++; a_tmo = r;
            if (end_at < 0) begin end_at = r; rdy_end = ready[d]; end
         end
         if (overrun[d]) begin n_ovr++; a_ovr = r; end
         if (end_at >= 0 && r == end_at + 1) rdy_after = ready[d];
         if (end_at >= 0 && r == end_at + 2) cnt_hold = int'(hic[d]);
         if (end_at >= 0 && r >= end_at + 3) break;
         // Drive this cycle's inputs.
         in_valid[d]   = (r == ov_in);
         siso_done[d]  = 1'b0;
         conv[d]       = 1'b0;
         deint_done[d] = 1'b0;
         if (np >= 1 && np <= 16 && d_q[np-1] >= 0 && r == last_start + d_q[np-1]) begin
            siso_done[d] = 1'b1;
            conv[d]      = c_q[np-1];
         end
         if (dstart >= 0 && e_dly >= 0 && r == dstart + e_dly) deint_done[d] = 1'b1;
         if (stray && dstart >= 0 && r == dstart + 1) begin
            siso_done[d] = 1'b1;
            conv[d]      = 1'b1;
         end
         if (stray && dstart < 0 && last_start >= 0 && r == last_start + 1) deint_done[d] = 1'b1;
      end
      clear_inputs();

      check({nm, ".n_load"}, n_load, 1);
      check({nm, ".load_at"}, a_load, 1);
      check({nm, ".n_start"}, np, x_np);
      for (int p = 0; p < x_np; p++) begin
         check($sformatf("%s.start%0d", nm, p), a_start[p], x_start[p]);
         check($sformatf("%s.sel%0d", nm, p), a_sel[p], x_sel[p]);
         check($sformatf("%s.apz%0d", nm, p), a_apz[p], x_apz[p]);
         check($sformatf("%s.cnt%0d", nm, p), a_cnt[p], p);
      end
      check({nm, ".n_deint"}, n_deint, (x_deint >= 0) ? 1 : 0);
      if (x_deint >= 0) check({nm, ".deint_at"}, a_deint, x_deint);
      check({nm, ".n_outv"}, n_outv, (x_outv >= 0) ? 1 : 0);
      if (x_outv >= 0) begin
         check({nm, ".outv_at"}, a_outv, x_outv);
         check({nm, ".ready_done"}, rdy_end, 0);
         check({nm, ".ready_after"}, rdy_after, 1);
      end
      check({nm, ".n_tmo"}, n_tmo, (x_tmo >= 0) ? 1 : 0);
      if (x_tmo >= 0) begin
         check({nm, ".tmo_at"}, a_tmo, x_tmo);
         check({nm, ".ready_tmo"}, rdy_end, 1);
      end
      check({nm, ".cnt_final"}, cnt_hold, x_cnt);
      check({nm, ".n_ovr"}, n_ovr, (ov_in > 0) ? 1 : 0);
      if (ov_in > 0) check({nm, ".ovr_at"}, a_ovr, ov_in + 1);
   endtask

   initial begin
      int n_bad;
      clear_inputs();
      reset = 1'b1;
      e_dly = 3; early_en = 1'b0;
      for (int i = 0; i < 16; i++) begin d_q[i] = 5; c_q[i] = 1'b0; end
      step(); step(); step();

      // Reset state of every configuration.
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst%0d.ready", i), ready[i], 1);
         check($sformatf("rst%0d.sel", i), siso_sel[i], 0);
         check($sformatf("rst%0d.apz", i), apriori_zero[i], 1);
         check($sformatf("rst%0d.cnt", i), hic[i], 0);
         check($sformatf("rst%0d.pulses", i),
               {overrun[i], load_en[i], siso_start[i], deint_start[i], out_valid[i], timeout_err[i]}, 0);
      end
      reset = 1'b0;
      step();

      // Normal two-pass frame ending in the interleaved domain.
      d_q[0] = 5; d_q[1] = 5; e_dly = 3; early_en = 1'b0;
      run_frame(0, -1, 1'b0, "normal");

      // Odd count: three passes, last in natural order, no deinterleave.
      d_q[0] = 4; d_q[1] = 3; d_q[2] = 6;
      run_frame(1, -1, 1'b0, "odd3");

      // Early stop: converged at k=1 ignored, honoured at k=2.
      early_en = 1'b1; e_dly = 2;
      d_q[0] = 4; c_q[0] = 1'b1; d_q[1] = 6; c_q[1] = 1'b1;
      run_frame(2, -1, 1'b0, "early2");
      // Early stop at k=3 in natural order goes straight to DONE.
      c_q[0] = 1'b0; c_q[1] = 1'b0; d_q[2] = 3; c_q[2] = 1'b1;
      run_frame(2, -1, 1'b0, "early3");
      for (int i = 0; i < 16; i++) c_q[i] = 1'b0;
      early_en = 1'b0;

      // Watchdog: SISO never answers, then a normal frame.
      d_q[0] = -1;
      run_frame(0, -1, 1'b0, "wdog");
      d_q[0] = 5; d_q[1] = 5; e_dly = 3;
      run_frame(0, -1, 1'b0, "after_wdog");
      // Done exactly on the expiry cycle wins.
      d_q[0] = 16; d_q[1] = 16; e_dly = 16;
      run_frame(0, -1, 1'b0, "wdog_edge");
      // Deinterleave that never finishes.
      d_q[0] = 3; d_q[1] = 3; e_dly = -1;
      run_frame(0, -1, 1'b0, "wdog_deint");

      // Overrun in WAIT with stray dones, then overrun on the DONE cycle.
      d_q[0] = 6; d_q[1] = 6; e_dly = 4;
      run_frame(0, 4, 1'b1, "ovr_wait");
      run_frame(0, -2, 1'b0, "ovr_done");

      // Reset in the second WAIT aborts the frame silently.
      n_bad = 0;
      in_valid[0] = 1'b1;
      for (int r = 1; r <= 40; r++) begin
         step();
         if (r == 10) begin
            check("rstmid.cnt_before", hic[0], 1);
            check("rstmid.sel_before", siso_sel[0], 1);
         end
         if (r == 11) begin
            check("rstmid.ready", ready[0], 1);
            check("rstmid.cnt", hic[0], 0);
            check("rstmid.sel", siso_sel[0], 0);
            check("rstmid.apz", apriori_zero[0], 1);
         end
         if (r >= 11 && (out_valid[0] || timeout_err[0] || siso_start[0] || load_en[0])) n_bad++;
         in_valid[0]  = 1'b0;
         siso_done[0] = (r == 7) || (r == 14);
         reset        = (r == 10);
      end
      clear_inputs();
      check("rstmid.no_events", n_bad, 0);
      check("rstmid.ready_end", ready[0], 1);

      // Randomized frames across all three configurations.
      for (int f = 0; f < 24; f++) begin
         int d;
         d        = int'($urandom_range(2, 0));
         early_en = bit'($urandom_range(1, 0));
         e_dly    = int'($urandom_range(8, 1));
         for (int p = 0; p < 16; p++) begin
            d_q[p] = (d == 0) ? int'($urandom_range(18, 1)) : int'($urandom_range(10, 1));
            c_q[p] = bit'($urandom_range(1, 0));
         end
         run_frame(d, -1, 1'b0, $sformatf("rnd%0d", f));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
